// File: rtl/inv_round_mix_seq_if.sv
// Upstream/downstream handshake bundle for the decryption round back-end.
interface inv_round_mix_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic [127:0] round_key;
    logic         last_round;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;

    modport master (
        output in_valid, state_in, round_key, last_round, out_ready,
        input  in_ready, out_valid, state_out
    );

    modport slave (
        input  in_valid, state_in, round_key, last_round, out_ready,
        output in_ready, out_valid, state_out
    );
endinterface

// File: rtl/inv_round_mix_seq.sv
// AES decryption round back-end: AddRoundKey then column-serial InvMixColumns.
// work[3] holds column 0 (bits 127:96), work[0] holds column 3.

// MixColumnHelper: InvMixColumns on one 32-bit column, byte [31:24] = row 0.
module mix_column_helper (
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) multiply by one of the InvMixColumns constants 09/0b/0d/0e
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] m);
        logic [7:0] x2, x4, x8, r;
        x2 = xt(b);
        x4 = xt(x2);
        x8 = xt(x4);
        r  = x8;
        if (m[0]) r = r ^ b;
        if (m[1]) r = r ^ x2;
        if (m[2]) r = r ^ x4;
        return r;
    endfunction

    logic [7:0] a0, a1, a2, a3;

    // Pure combinational column transform
    always_comb begin
        a0 = col_in[31:24];
        a1 = col_in[23:16];
        a2 = col_in[15:8];
        a3 = col_in[7:0];
        col_out = {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
                   gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
                   gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
                   gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
    end
endmodule

module inv_round_mix_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    inv_round_mix_seq_if.slave bus,
    output logic              busy
);
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
        $error("inv_round_mix_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                           state, state_nxt;
    logic [3:0][31:0]                 work, work_nxt;
    logic [1:0]                       col, col_nxt;
    logic [127:0]                     sout, sout_nxt;
    logic [COLS_PER_CYCLE-1:0][1:0]   cidx;
    logic [COLS_PER_CYCLE-1:0][31:0]  col_in, col_out;
    logic                             last_step;

    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
        mix_column_helper u_mix (.col_in(col_in[k]), .col_out(col_out[k]));
    end

    // Column indices handled this cycle; ~idx maps column number to work slot
    always_comb begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            cidx[k]   = col + 2'(k);
            col_in[k] = work[~cidx[k]];
        end
        last_step = (col + 2'(COLS_PER_CYCLE - 1)) == 2'd3;
    end

    // Next-state, work update and result capture
    always_comb begin
        state_nxt = state;
        work_nxt  = work;
        col_nxt   = col;
        sout_nxt  = sout;
        case (state)
            IDLE: begin
                if (bus.in_valid && bus.in_ready) begin
                    work_nxt = bus.state_in ^ bus.round_key;
                    col_nxt  = 2'd0;
                    if (bus.last_round) begin
                        state_nxt = DONE;
                        sout_nxt  = bus.state_in ^ bus.round_key;
                    end else begin
                        state_nxt = CALC;
                    end
                end
            end
            CALC: begin
                for (int k = 0; k < COLS_PER_CYCLE; k++)
                    work_nxt[~cidx[k]] = col_out[k];
                col_nxt = col + 2'(COLS_PER_CYCLE);
                if (last_step) begin
                    state_nxt = DONE;
                    sout_nxt  = work_nxt;
                end
            end
            DONE: begin
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State registers; reset discards any in-flight work
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            work  <= '0;
            col   <= 2'd0;
            sout  <= '0;
        end else begin
            state <= state_nxt;
            work  <= work_nxt;
            col   <= col_nxt;
            sout  <= sout_nxt;
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.state_out = sout;
    assign busy          = (state != IDLE);
endmodule

// File: tb/tb_inv_round_mix_seq.sv
// Directed bench: three instances at COLS_PER_CYCLE = 1, 2, 4.
module tb_inv_round_mix_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         iv   [3];
    logic         ordy [3];
    logic         lr   [3];
    logic [127:0] sin  [3];
    logic [127:0] key  [3];
    logic         ir   [3];
    logic         ov   [3];
    logic         bsy  [3];
    logic [127:0] sout [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        inv_round_mix_seq_if bus ();
        assign bus.in_valid   = iv[g];
        assign bus.state_in   = sin[g];
        assign bus.round_key  = key[g];
        assign bus.last_round = lr[g];
        assign bus.out_ready  = ordy[g];
        assign ir[g]          = bus.in_ready;
        assign ov[g]          = bus.out_valid;
        assign sout[g]        = bus.state_out;
        inv_round_mix_seq #(.COLS_PER_CYCLE(1 << g)) dut (
            .clk  (clk),
            .rst  (rst),
            .bus  (bus.slave),
            .busy (bsy[g])
        );
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [127:0] s;
        logic [127:0] k;
        logic         lr;
        logic [127:0] exp;
        int           lat;
        int           hold;
    } vec_t;

    vec_t tbl [5];
    vec_t rv  [4];

    // One transaction on instance g, with optional backpressure cycles
    task automatic run_txn(input int g, input vec_t v, input string nm);
        int n;
        int lat;
        @(negedge clk);
        iv[g] = 1'b1; sin[g] = v.s; key[g] = v.k; lr[g] = v.lr; ordy[g] = 1'b0;
        n = 0;
        while (!ir[g] && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        iv[g] = 1'b0; sin[g] = ~v.s; key[g] = ~v.k; lr[g] = ~v.lr;
        lat = 0;
        while (lat < 50) begin
            @(negedge clk); lat++;
            if (ov[g]) break;
        end
        chk({nm, " latency"}, 128'(lat), 128'(v.lat));
        chk({nm, " data"}, sout[g], v.exp);
        for (int i = 0; i < v.hold; i++) begin
            iv[g] = 1'b1; sin[g] = 128'h5a5a; key[g] = '0; lr[g] = 1'b1;
            @(negedge clk);
            chk({nm, " hold valid"}, 128'(ov[g]), 128'd1);
            chk({nm, " hold data"}, sout[g], v.exp);
            chk({nm, " hold in_ready"}, 128'(ir[g]), 128'd0);
        end
        iv[g] = 1'b0; ordy[g] = 1'b1;
        @(posedge clk); #1;
        ordy[g] = 1'b0;
        @(negedge clk);
        chk({nm, " post out_valid"}, 128'(ov[g]), 128'd0);
        chk({nm, " post in_ready"}, 128'(ir[g]), 128'd1);
    endtask

    // Back-to-back stream with in_valid held high and out_ready=1
    task automatic run_stream(input int g, input int sp);
        int  idx, nout, last;
        logic acc;
        idx = 0; nout = 0; last = 0;
        @(negedge clk);
        iv[g] = 1'b1; ordy[g] = 1'b1;
        sin[g] = rv[0].s; key[g] = rv[0].k; lr[g] = 1'b0;
        for (int cyc = 0; cyc < 100 && nout < 4; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (ov[g]) begin
                chk($sformatf("stream g%0d out%0d", g, nout), sout[g], rv[nout].exp);
                nout++;
            end
            acc = ir[g] && iv[g];
            if (acc) begin
                if (idx > 0) chk($sformatf("stream g%0d spacing", g), 128'(cyc - last), 128'(sp));
                last = cyc;
            end
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 4) begin sin[g] = rv[idx].s; key[g] = rv[idx].k; end
                else iv[g] = 1'b0;
            end
        end
        chk($sformatf("stream g%0d count", g), 128'(nout), 128'd4);
        iv[g] = 1'b0; ordy[g] = 1'b0;
    endtask

    initial begin
        tbl[0] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'h0, 1'b0,
                   128'hdb135345_f20a225c_01010101_c6c6c6c6, 5, 0};
        tbl[1] = '{128'h0, 128'h4d7ebdf8_d5d5d7d6_8e4da1bc_01010101, 1'b0,
                   128'h2d26314c_d4d4d4d5_db135345_01010101, 5, 0};
        tbl[2] = '{128'h00112233_44556677_8899aabb_ccddeeff, 128'h00010203_04050607_08090a0b_0c0d0e0f, 1'b1,
                   128'h00102030_40506070_8090a0b0_c0d0e0f0, 1, 0};
        tbl[3] = '{128'h0, 128'h0, 1'b0, 128'h0, 5, 0};
        tbl[4] = '{128'h0, 128'h4d7ebdf8_d5d5d7d6_8e4da1bc_01010101, 1'b0,
                   128'h2d26314c_d4d4d4d5_db135345_01010101, 5, 10};

        rv[0] = tbl[0];
        rv[1] = tbl[1];
        rv[2] = '{128'hc6c6c6c6_d5d5d7d6_4d7ebdf8_9fdc589d, 128'h0, 1'b0,
                  128'hc6c6c6c6_d4d4d4d5_2d26314c_f20a225c, 0, 0};
        rv[3] = '{128'hffffffff_ffffffff_ffffffff_ffffffff, 128'h71b25e43_6023a762_fefefefe_39393939, 1'b0,
                  128'hdb135345_f20a225c_01010101_c6c6c6c6, 0, 0};

        for (int g = 0; g < 3; g++) begin
            iv[g] = 1'b0; ordy[g] = 1'b0; lr[g] = 1'b0; sin[g] = '0; key[g] = '0;
        end

        // Reset state on every instance
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("reset g%0d out_valid", g), 128'(ov[g]), 128'd0);
            chk($sformatf("reset g%0d in_ready", g), 128'(ir[g]), 128'd1);
            chk($sformatf("reset g%0d busy", g), 128'(bsy[g]), 128'd0);
            chk($sformatf("reset g%0d state_out", g), sout[g], 128'h0);
        end
        rst = 1'b0;

        // Directed table on the single-column instance (last entry has backpressure)
        for (int i = 0; i < 5; i++) run_txn(0, tbl[i], $sformatf("vec%0d", i));

        // Reset during the second CALC cycle
        @(negedge clk);
        iv[0] = 1'b1; sin[0] = tbl[0].s; key[0] = tbl[0].k; lr[0] = 1'b0;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst out_valid", 128'(ov[0]), 128'd0);
        chk("midrst busy", 128'(bsy[0]), 128'd0);
        chk("midrst in_ready", 128'(ir[0]), 128'd1);
        chk("midrst state_out", sout[0], 128'h0);
        run_txn(0, tbl[0], "after rst");

        // Back-to-back streams on each width
        run_stream(0, 6);
        run_stream(1, 4);
        run_stream(2, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
